decoder_3to8: RTL and testbench

Registered binary-to-one-hot decoder with enable: a 3-bit index selects one of 8 output lines. Output is registered on the clock with asynchronous active-low reset. Used wherever a select index must drive one-hot enables, for example register-bank write strobes or mux selects.

---
 rtl/decoder_pkg.sv | 29 ++
 rtl/decoder_core.sv | 33 +++
 rtl/decoder_3to8.sv | 72 +++++++
 tb/tb_decoder_3to8.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the registered 3-to-8 one-hot decoder.
//   DEC_IN_W      : index width (3)
//   DEC_OUT_W     : number of one-hot lines (8)
//   dec_onehot_t  : one-hot vector type
//   dec_onehot()  : next-state one-hot value for a given enable and index
// -----------------------------------------------------------------------------
package decoder_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 1 << DEC_IN_W;

  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

  // Each bit is set only when the enable and the index compare are both true.
  // An X/Z on either input makes the compare unknown, so the branch is not
  // taken and the bit keeps its zero default instead of turning X.
  function automatic dec_onehot_t dec_onehot(input logic en,
                                             input logic [DEC_IN_W-1:0] idx);
    dec_onehot_t v;
    v = '0;
    for (int k = 0; k < DEC_OUT_W; k++) begin
      if (en && (idx == DEC_IN_W'(k))) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// -----------------------------------------------------------------------------
// decoder_core
// Purely combinational binary-to-one-hot decode with enable.
//   en      in   1        : decode enable; all-zero result when low
//   in      in   IN_W     : binary index
//   onehot  out  2**IN_W  : one-hot result (bit k set when in == k and en)
// -----------------------------------------------------------------------------
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W = DEC_IN_W
) (
  input  logic                 en,
  input  logic [IN_W-1:0]      in,
  output logic [(2**IN_W)-1:0] onehot
);

  generate
    if (IN_W == DEC_IN_W) begin : g_pkg
      assign onehot = dec_onehot(en, in);
    end else begin : g_generic
      always_comb begin
        // NOTE: default every bit first so no path leaves onehot unassigned
        // (which would infer a latch).
        onehot = '0;
        for (int k = 0; k < 2**IN_W; k++) begin
          if (en && (in == IN_W'(k))) onehot[k] = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/decoder_3to8.sv
// -----------------------------------------------------------------------------
// decoder_3to8
// Registered binary-to-one-hot decoder with enable. One cycle of latency,
// no combinational path from inputs to outputs.
//   clk    in   1      : clock, rising edge
//   rst_n  in   1      : asynchronous active-low reset
//   en     in   1      : decode enable
//   in     in   IN_W   : binary index
//   out    out  OUT_W  : registered one-hot result
//   hit    out  1      : registered flag, high when any out bit is high
//   out_n  out  OUT_W  : registered active-low copy of out
//                        (only when DECODER_ACTIVE_LOW_EN is defined)
// Build option: DECODER_ACTIVE_LOW_EN adds out_n and its register.
// -----------------------------------------------------------------------------
module decoder_3to8
  import decoder_pkg::*;
#(
  parameter  int IN_W  = DEC_IN_W,
  localparam int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             hit
`ifdef DECODER_ACTIVE_LOW_EN
  ,
  output logic [OUT_W-1:0] out_n
`endif
);

  logic [OUT_W-1:0] onehot;

  decoder_core #(
    .IN_W (IN_W)
  ) u_core (
    .en     (en),
    .in     (in),
    .onehot (onehot)
  );

  // hit is derived from the decoded value rather than from en directly so an
  // unknown en cannot leak X into the flag; for known inputs the two agree.
  logic hit_d;
  assign hit_d = |onehot;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      hit <= 1'b0;
    end else begin
      out <= onehot;
      hit <= hit_d;
    end
  end

`ifdef DECODER_ACTIVE_LOW_EN
  // Kept as its own register (not an inverter after out) so out_n is a clean
  // flop output with the same timing as out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_n <= '1;
    end else begin
      out_n <= ~onehot;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8
// Self-checking bench for decoder_3to8: reset, table of directed vectors,
// asynchronous reset mid-stream, and randomized stimulus against a reference
// model that computes the expected one-hot value as a power of two.
// -----------------------------------------------------------------------------
module tb_decoder_3to8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] in;
  logic [7:0] out;
  logic       hit;
`ifdef DECODER_ACTIVE_LOW_EN
  logic [7:0] out_n;
`endif

  int total = 0;
  int bad   = 0;

  decoder_3to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .out   (out),
    .hit   (hit)
`ifdef DECODER_ACTIVE_LOW_EN
    ,
    .out_n (out_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] in;
    logic [7:0] exp_out;
    logic       exp_hit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Reference: enabled decode is 2 to the power of the index, else zero.
  function automatic logic [7:0] model_out(input logic e, input int idx);
    int v;
    v = e ? (2 ** idx) : 0;
    return v[7:0];
  endfunction

  task automatic check_outputs(input string name, input logic [7:0] exp_out,
                               input logic exp_hit);
    check({name, ".out"}, 32'(out), 32'(exp_out));
    check({name, ".hit"}, 32'(hit), 32'(exp_hit));
`ifdef DECODER_ACTIVE_LOW_EN
    check({name, ".out_n"}, 32'(out_n), 32'(~exp_out));
`endif
  endtask

  // Drive inputs, let one rising edge capture them, sample shortly after.
  task automatic apply(input logic e, input logic [2:0] i);
    en = e;
    in = i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with an active-looking input; clock keeps toggling.
    rst_n = 1'b0;
    en    = 1'b1;
    in    = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset.out", 32'(out), 32'h00);
    check("reset.hit", 32'(hit), 32'h0);
`ifdef DECODER_ACTIVE_LOW_EN
    check("reset.out_n", 32'(out_n), 32'hFF);
`endif

    // Release between edges; first update happens at the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 3'(i), 8'(1 << i), 1'b1});
    vecs.push_back('{1'b0, 3'd0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 3'd3, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 3'd7, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 8'h40, 1'b1});
    vecs.push_back('{1'b0, 3'd6, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 3'd6, 8'h40, 1'b1});
    vecs.push_back('{1'b1, 3'd1, 8'h02, 1'b1});

    foreach (vecs[v]) begin
      apply(vecs[v].en, vecs[v].in);
      check_outputs($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_hit);
    end

    // Asynchronous reset mid-stream.
    apply(1'b1, 3'd2);
    check_outputs("async.pre", 8'h04, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs("async.during", 8'h00, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    check_outputs("async.released", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("async.resume", 8'h04, 1'b1);

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic       e;
      logic [2:0] i;
      e = 1'($urandom_range(0, 3) != 0);
      i = 3'($urandom_range(0, 7));
      apply(e, i);
      check_outputs($sformatf("rand%0d", n), model_out(e, int'(i)), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
